// File: rtl/fetch_stage_pkg.sv
// Types and constants shared by the instruction fetch stage and its skid buffer.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2,
    BUF   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that arrived while decode was stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] buf_instr,
  output logic [31:0] buf_pc,
  output logic        buf_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end
  end

  // Payload is qualified by buf_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_instr <= load_instr;
      buf_pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory, fills the IF/ID register,
// and handles decode stalls (via a skid buffer) and taken-branch redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        brench,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_reg,
  output logic [31:0] pc_reg,
  output logic        id_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  kill_addr;
  logic [31:0]  target_aligned;
  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc;
  logic         buf_valid;

  assign target_aligned = align_word(branch_target);

  // A killed request keeps presenting its original address until its ack returns.
  assign imem_req  = (state == FETCH) || (state == KILL);
  assign imem_addr = (state == KILL) ? kill_addr : pc;

  assign skid_load  = (state == FETCH) && imem_ack && !brench && stall;
  assign skid_clear = (state == BUF) && (brench || !stall);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc),
    .buf_instr  (buf_instr),
    .buf_pc     (buf_pc),
    .buf_valid  (buf_valid)
  );

  always_ff @(posedge clk) begin
    if ((state == FETCH) && brench && !imem_ack) begin
      kill_addr <= pc;
    end
  end

  // Fetch FSM plus PC and IF/ID register; a branch flush takes priority over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      id_valid  <= 1'b0;
    end else if (brench) begin
      instr_reg <= NOP_INSTR;
      id_valid  <= 1'b0;
      pc        <= target_aligned;
      if (((state == FETCH) || (state == KILL)) && !imem_ack) begin
        state <= KILL;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            pc <= pc_inc(pc);
            if (stall) begin
              state <= BUF;
            end else begin
              instr_reg <= imem_rdata;
              pc_reg    <= pc;
              id_valid  <= 1'b1;
            end
          end else if (!stall) begin
            instr_reg <= NOP_INSTR;
            id_valid  <= 1'b0;
          end
        end
        KILL: begin
          if (imem_ack) begin
            state <= FETCH;
          end
          if (!stall) begin
            instr_reg <= NOP_INSTR;
            id_valid  <= 1'b0;
          end
        end
        BUF: begin
          if (!stall && buf_valid) begin
            instr_reg <= buf_instr;
            pc_reg    <= buf_pc;
            id_valid  <= 1'b1;
            state     <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level reference model checked every cycle.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        brench = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;
  logic        id_valid;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_on = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = word_of(imem_addr);

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .brench        (brench),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_reg     (instr_reg),
    .pc_reg        (pc_reg),
    .id_valid      (id_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one outstanding request, possibly marked as discarded,
  // or a parked word waiting for the stall to drop.
  logic        m_started, m_discard, m_have_buf, m_vld;
  logic [31:0] m_pc, m_kaddr, m_buf_i, m_buf_pc, m_instr, m_pcr;
  logic [31:0] m_cur, m_tgt;
  logic        m_req;

  assign m_cur = m_discard ? m_kaddr : m_pc;
  assign m_tgt = {branch_target[31:2], 2'b00};
  assign m_req = m_started && !m_have_buf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started  <= 1'b0;
      m_discard  <= 1'b0;
      m_have_buf <= 1'b0;
      m_pc       <= 32'h0;
      m_kaddr    <= 32'h0;
      m_buf_i    <= 32'h0;
      m_buf_pc   <= 32'h0;
      m_instr    <= NOP;
      m_pcr      <= 32'h0;
      m_vld      <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
      if (brench) begin
        m_instr <= NOP;
        m_vld   <= 1'b0;
        m_pc    <= m_tgt;
      end
    end else if (m_have_buf) begin
      if (brench) begin
        m_instr    <= NOP;
        m_vld      <= 1'b0;
        m_pc       <= m_tgt;
        m_have_buf <= 1'b0;
      end else if (!stall) begin
        m_instr    <= m_buf_i;
        m_pcr      <= m_buf_pc;
        m_vld      <= 1'b1;
        m_have_buf <= 1'b0;
      end
    end else begin
      if (imem_ack) m_discard <= 1'b0;
      if (brench) begin
        m_instr <= NOP;
        m_vld   <= 1'b0;
        m_pc    <= m_tgt;
        if (!imem_ack) begin
          m_kaddr   <= m_cur;
          m_discard <= 1'b1;
        end
      end else if (imem_ack && !m_discard) begin
        m_pc <= m_pc + 32'd4;
        if (stall) begin
          m_buf_i    <= word_of(m_cur);
          m_buf_pc   <= m_cur;
          m_have_buf <= 1'b1;
        end else begin
          m_instr <= word_of(m_cur);
          m_pcr   <= m_cur;
          m_vld   <= 1'b1;
        end
      end else if (!stall) begin
        m_instr <= NOP;
        m_vld   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", imem_addr, m_cur);
      chk("instr_reg", instr_reg, m_instr);
      chk("pc_reg", pc_reg, m_pcr);
      chk("id_valid", 32'(id_valid), 32'(m_vld));
    end
  end

  task automatic cyc(input logic a, input logic s, input logic b, input logic [31:0] t);
    imem_ack = a;
    stall = s;
    brench = b;
    branch_target = t;
    @(negedge clk);
    #1;
  endtask

  task automatic reset_now();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_instr", instr_reg, NOP);
    chk("rst_pc_reg", pc_reg, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("init_req", 32'(imem_req), 32'h0);
    chk("init_instr", instr_reg, NOP);
    chk("init_valid", 32'(id_valid), 32'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    cyc(1, 0, 0, 0);   // stale ack during IDLE is ignored
    chk("idle_req", 32'(imem_req), 32'h1);
    chk("idle_addr", imem_addr, 32'h0);
    chk("idle_valid", 32'(id_valid), 32'h0);
    cyc(1, 0, 0, 0);
    chk("f0_instr", instr_reg, 32'hDEAD_0000);
    chk("f0_pc", pc_reg, 32'h0);
    chk("f0_next", imem_addr, 32'h4);
    cyc(1, 0, 0, 0);
    chk("f4_pc", pc_reg, 32'h4);
    chk("f4_next", imem_addr, 32'h8);
    cyc(1, 1, 0, 0);   // stall on ack for pc 8
    chk("buf_req", 32'(imem_req), 32'h0);
    chk("buf_hold_pc", pc_reg, 32'h4);
    cyc(0, 1, 0, 0);
    chk("buf_hold_req", 32'(imem_req), 32'h0);
    cyc(0, 0, 0, 0);
    chk("drain_instr", instr_reg, 32'hDEAD_0008);
    chk("drain_pc", pc_reg, 32'h8);
    chk("drain_next", imem_addr, 32'hC);
    cyc(1, 0, 0, 0);
    chk("fc_instr", instr_reg, 32'hDEAD_000C);
    cyc(0, 0, 0, 0);
    chk("bubble_valid", 32'(id_valid), 32'h0);
    chk("bubble_instr", instr_reg, NOP);
    cyc(0, 0, 1, 32'h100);   // redirect with request for 0x10 pending
    chk("kill_req", 32'(imem_req), 32'h1);
    chk("kill_addr", imem_addr, 32'h10);
    cyc(1, 0, 0, 0);
    chk("kill_drop_valid", 32'(id_valid), 32'h0);
    chk("kill_next", imem_addr, 32'h100);
    cyc(1, 0, 0, 0);
    chk("tgt_instr", instr_reg, 32'hDEAD_0100);
    chk("tgt_pc", pc_reg, 32'h100);
    cyc(1, 1, 1, 32'h200);   // flush beats stall and ack
    chk("flush_instr", instr_reg, NOP);
    chk("flush_addr", imem_addr, 32'h200);
    cyc(0, 0, 1, 32'h300);
    cyc(0, 1, 1, 32'h400);
    chk("kill2_addr", imem_addr, 32'h200);
    cyc(1, 1, 0, 0);
    chk("kill2_next", imem_addr, 32'h400);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("f400_instr", instr_reg, 32'hDEAD_0400);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'hFFFF_FFFD);   // flush out of the buffered state
    chk("bufflush_addr", imem_addr, 32'hFFFF_FFFC);
    chk("bufflush_valid", 32'(id_valid), 32'h0);
    cyc(1, 0, 0, 0);
    chk("wrap_instr", instr_reg, 32'h2152_FFFC);
    chk("wrap_next", imem_addr, 32'h0);
    cyc(1, 0, 1, 32'h103);
    chk("align_addr", imem_addr, 32'h100);
    cyc(1, 1, 0, 0);   // buffer now full
    chk("full_req", 32'(imem_req), 32'h0);

    reset_now();
    cyc(1, 0, 0, 0);
    chk("rst1_addr", imem_addr, 32'h0);
    chk("rst1_valid", 32'(id_valid), 32'h0);
    cyc(0, 0, 0, 0);   // request pending
    reset_now();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst2_instr", instr_reg, 32'hDEAD_0000);
    chk("rst2_next", imem_addr, 32'h4);

    for (int i = 0; i < 48; i++) begin
      cyc(((i % 2) == 0) || ((i % 5) == 0), (i % 7) == 3, (i % 11) == 6,
          32'h1000 + 32'(i * 8) + 32'(i % 4));
    end
    cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
